// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transmitter.
// The FSM state enum and the frame-shape constants live here.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-push handshake between a producer and the UART transmitter FIFO.
// A byte transfers on a rising edge where in_valid && in_ready.
interface uart_tx_if;
    import uart_pkg::*;

    logic                 in_valid;
    logic [DATA_BITS-1:0] in_data;
    logic                 in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous power-of-two FIFO feeding the transmitter; a push while full is
// rejected even when a pop happens on the same edge.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                 uart_clk,
    input  logic                 rst_n,
    input  logic                 push_i,
    input  logic [DATA_BITS-1:0] wdata_i,
    input  logic                 pop_i,
    output logic [DATA_BITS-1:0] rdata_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [AW:0]          level_o
);

    localparam logic [AW:0] FullLevel = (AW + 1)'(DEPTH);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          level_q, level_d;
    logic                 push_ok, pop_ok;

    assign full_o  = (level_q == FullLevel);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + (AW + 1)'(1);
            2'b01:   level_d = level_q - (AW + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge uart_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: FIFO-buffered byte input, DIV clocks per serial bit,
// back-to-back frames with no idle gap while the FIFO has data.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned  DIV   = 10,
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned CW    = $clog2(DIV),
    localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic          uart_clk,
    input  logic          rst_n,
    uart_tx_if.slave      in_if,
    output logic          tx_data,
    output logic          busy,
    output logic [LW-1:0] level
);

    localparam logic [CW-1:0] CntLoad  = CW'(DIV - 1);
    localparam logic [2:0]    LastData = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LastStop = 3'(STOP_BITS - 1);

    tx_state_e            state_q;
    logic [CW-1:0]        cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [2:0]           bit_idx_q;
    logic                 tx_q;

    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic [LW-1:0]        fifo_level;
    logic                 bit_end;
    logic                 stop_done;

    uart_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .uart_clk (uart_clk),
        .rst_n    (rst_n),
        .push_i   (in_if.in_valid),
        .wdata_i  (in_if.in_data),
        .pop_i    (fifo_pop),
        .rdata_o  (fifo_rdata),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .level_o  (fifo_level)
    );

    assign bit_end   = (cnt_q == '0);
    assign stop_done = (state_q == STOP) && bit_end && (bit_idx_q == LastStop);

    // Head byte is taken either from idle or straight out of the last stop bit.
    assign fifo_pop = !fifo_empty && ((state_q == IDLE) || stop_done);

    assign in_if.in_ready = !fifo_full;
    assign tx_data        = tx_q;
    assign level          = fifo_level;
    assign busy           = (state_q != IDLE) || (fifo_level != '0);

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty) begin
                        shift_q <= fifo_rdata;
                        tx_q    <= 1'b0;
                        cnt_q   <= CntLoad;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx_q      <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= '0;
                        cnt_q     <= CntLoad;
                        state_q   <= DATA;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q <= CntLoad;
                        if (bit_idx_q == LastData) begin
                            tx_q      <= 1'b1;
                            bit_idx_q <= '0;
                            state_q   <= STOP;
                        end else begin
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                STOP: begin
                    if (stop_done) begin
                        if (!fifo_empty) begin
                            shift_q <= fifo_rdata;
                            tx_q    <= 1'b0;
                            cnt_q   <= CntLoad;
                            state_q <= START;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else if (bit_end) begin
                        bit_idx_q <= bit_idx_q + 3'd1;
                        cnt_q     <= CntLoad;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DIV, default 10: uart_clk cycles per serial bit (100 MHz / 10 Mbps); legal range DIV >= 2.
REQ-002 SHALL have parameter DEPTH, default 4: transmit FIFO entries; power of two, >= 2.
REQ-003 SHALL have port uart_clk, input, 1: the single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset; one clock, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1: in_data holds a byte to send.
REQ-006 SHALL have port in_data, input, 8: byte to send, LSB transmitted first.
REQ-007 SHALL have port in_ready, output, 1: FIFO can accept a byte this cycle.
REQ-008 SHALL have port tx_data, output, 1: serial line, idle high, registered.
REQ-009 SHALL have port busy, output, 1: a frame is in progress or the FIFO is non-empty.
REQ-010 SHALL have port level, output, $clog2(DEPTH)+1: current FIFO occupancy.

Function
REQ-011 SHALL accept a byte on a rising edge where in_valid && in_ready; in_data is ignored otherwise.
REQ-012 SHALL drive in_ready = (level != DEPTH), combinationally from FIFO state only, never from in_valid.
REQ-013 SHALL reject a push when full even if a pop occurs the same edge; no overwrite, no drop of stored data.
REQ-014 SHALL apply push and pop on the same edge when not full and not empty; level unchanged.
REQ-015 SHALL send 8N1 frames: start bit 0, in_data[0..7], stop bit 1; each bit held exactly DIV cycles, so a frame is 10*DIV cycles.
REQ-016 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-017 IDLE: tx_data=1; when FIFO non-empty, pop head into shift register and go to START.
REQ-018 START: tx_data=0 for DIV cycles, then go to DATA with bit index 0.
REQ-019 DATA: tx_data = shift[0] for DIV cycles per bit; shift right each bit; after bit 7 go to STOP.
REQ-020 STOP: tx_data=1 for DIV cycles; at the end, pop next byte and go directly to START if FIFO non-empty, else go to IDLE.
REQ-021 SHALL time bits with a down-counter of width $clog2(DIV), loaded with DIV-1 on entry to each bit and decremented to 0; the bit ends when the counter equals 0.
REQ-022 Latency: byte accepted on edge N with FSM in IDLE and FIFO empty -> tx_data low from edge N+1.
REQ-023 Back-to-back: no idle cycle between the stop bit of one frame and the start bit of the next.
REQ-024 busy SHALL be 0 only in IDLE with level==0.
REQ-025 tx_data SHALL never glitch or return to X after reset; the output changes only on bit boundaries.

Reset
REQ-026 On rst_n low, asynchronously: tx_data=1, state=IDLE, level=0, busy=0, in_ready=1, counter=0, FIFO pointers=0.
REQ-027 Reset mid-frame SHALL abort the frame immediately and discard all FIFO contents; the line returns high at once.
REQ-028 Reset release SHALL be synchronous to uart_clk; the first push is accepted on the first edge with rst_n high.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state enum (IDLE, START, DATA, STOP) and constants DATA_BITS=8, STOP_BITS=1.
REQ-030 SHALL instantiate one sub-module, uart_tx_fifo (synchronous FIFO with parameter DEPTH, push/pop/full/empty/level ports, same uart_clk and rst_n).
REQ-031 Shift register, bit index (3 bits) and baud counter SHALL live in uart_tx itself.

Verification
REQ-032 Single byte 0x55 with DIV=10 -> tx_data low from edge N+1, then bits 1,0,1,0,1,0,1,0 each 10 cycles, stop high, busy low after 100 cycles.
REQ-033 Push "Hi\n" (0x48,0x69,0x0A) back-to-back -> three contiguous 100-cycle frames with no idle gap; the downstream UART monitor prints the line "Hi".
REQ-034 Push 6 bytes with in_valid held high, DEPTH=4 -> in_ready drops when level==4, no byte lost or duplicated; serial output equals the push order.
REQ-035 Assert rst_n low at the middle of bit 3 of a frame with 2 bytes queued -> tx_data=1 immediately, level=0, no further frames after release.
REQ-036 DIV=2 with byte 0xFF -> 20-cycle frame: 2 cycles low, then 18 cycles high; the counter wraps correctly.
